mem_req_mux: RTL and testbench
==============================

# mem_req_mux

Parametrised N-channel request multiplexer with round-robin arbitration. It merges memory requests from several cache-side masters, such as I-cache and D-cache refill/writeback, onto one memory port. It registers the winning request, holds it stable until the memory acknowledges, then returns a one-cycle acknowledge and the read data to the winner. It replaces hard-wired 2:1 data selection on the memory path wherever more than one master shares the port.

## Interface
Parameters:
- N, 2, number of requesting channels (N ≥ 2)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N  per-channel request; must stay high, with its fields stable, until that channel's ack
- req_we  in  N  per-channel write enable (1 = write)
- req_addr  in  N*AW  flattened; channel i at [i*AW +: AW]
- req_wdata  in  N*DW  flattened; channel i at [i*DW +: DW]
- ack  out  N  one-hot, one-cycle completion pulse to the granted channel
- rdata  out  DW  registered read data, valid in the ack cycle
- grant_id  out  $clog2(N)  index of the channel currently granted (debug/monitor)
- busy  out  1  high while in BUSY or DONE
- mem_cs  out  1  memory request strobe, registered
- mem_we  out  1  registered
- mem_addr  out  AW  registered
- mem_wdata  out  DW  registered
- mem_ack  in  1  memory completion, sampled only in BUSY
- mem_rdata  in  DW  sampled on the edge where mem_ack is seen in BUSY

## Operation
- States:
  - IDLE: no transaction in progress.
  - BUSY: mem_* driven, waiting for mem_ack.
  - DONE: ack pulse cycle.
- IDLE, with any req_valid high:
  - Select the first channel with valid high, searching last+1, last+2, … modulo N.
  - Load mem_cs=1 and mem_we/mem_addr/mem_wdata from the selected channel.
  - Set grant_id and last to the selected index; go to BUSY.
- IDLE, with no request: outputs hold; mem_cs=0.
- BUSY:
  - mem_* held constant.
  - Changes on req_* inputs are ignored, including withdrawal by the granted channel (protocol violation; the transaction still completes).
  - On mem_ack=1: mem_cs←0; rdata←mem_rdata if mem_we=0, otherwise rdata holds its value; ack[grant_id]←1; go to DONE.
- DONE:
  - ack is high for exactly this one cycle.
  - ack←0 at the next edge; go to IDLE.
  - The granted master must drop req_valid on the edge after it sees ack.
- mem_ack is ignored in IDLE and DONE.
- Pointer:
  - last resets to N-1, so channel 0 wins first.
  - last updates only on a grant.
  - Pointer arithmetic wraps modulo N, including non-power-of-2 N.
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,N-1,0,…; no channel waits more than N-1 transactions.

## Timing
- Reset (asynchronous, immediate) values:
  - State IDLE, last=N-1.
  - ack=0, rdata=0, grant_id=0, busy=0.
  - mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-transaction: the transaction is abandoned. mem_cs drops immediately and no ack is issued. Memory must tolerate cs dropping without an ack.
- Request sampled in IDLE at edge k → mem_cs=1 from edge k (visible during cycle k+1).
- mem_ack sampled at edge m → mem_cs=0 and ack/rdata valid during cycle m+1; IDLE from edge m+1.
- Minimum transaction, with mem_ack high the first BUSY cycle: 3 cycles from grant to return to IDLE.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- Simultaneous requests in IDLE: exactly one grant per IDLE cycle, chosen by round-robin order.
- Combinational paths from inputs to outputs: none. All outputs are registered.

## Test plan
- Reset with no requests: after rst pulse, all outputs are 0. Set req_valid=01, addr0=0x100, we0=0, then mem_ack one cycle later with mem_rdata=0xDEADBEEF → mem_addr=0x100 and mem_cs=1 for the BUSY cycles; ack=01 for exactly one cycle with rdata=0xDEADBEEF.
- Both channels request continuously, N=2, mem_ack fixed at 1 → grant_id sequence 0,1,0,1; each ack is one cycle; grants are spaced 3 cycles apart.
- N=3 with non-power-of-2 wrap: last=2 and requests 101 → channel 0 granted. Then requests 101 → channel 2. Then 101 → channel 0.
- Write transaction: ch1 we=1, addr=0x2000, wdata=0x12345678, with mem_ack delayed 5 cycles → mem_* stable for all 5 BUSY cycles. ch0 requests arriving mid-way are not granted until after DONE; rdata holds its prior value.
- Reset asserted during BUSY: mem_cs falls asynchronously, no ack pulse follows, and after reset release the next grant goes to channel 0.
- Spurious mem_ack in IDLE and in DONE → no state change and no extra ack pulse.

Source files
------------

// File: rtl/mem_req_mux_if.sv
// Bus bundle for mem_req_mux: per-channel request side, acknowledge/read-data return
// and the single registered memory port.
interface mem_req_mux_if #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int GW = $clog2(N);

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic            mem_cs;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    // The mux itself sits on the slave side of this bundle.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        output ack, rdata, grant_id, busy, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        input  ack, rdata, grant_id, busy, mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_mux.sv
// N-channel round-robin memory request multiplexer: registers the winning request,
// holds it until the memory acknowledges, then returns a one-cycle ack with read data.
module mem_req_mux #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic          clk,
    input logic          rst,
    mem_req_mux_if.slave bus
);
    localparam int GW = $clog2(N);
    localparam logic [N-1:0] ACK_ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [GW-1:0]  last;
    logic [GW-1:0]  grant_q;
    logic [GW-1:0]  sel_idx;
    logic           sel_found;
    logic [GW:0]    cand;

    logic [N-1:0]   ack_q;
    logic [DW-1:0]  rdata_q;
    logic           busy_q;
    logic           mem_cs_q;
    logic           mem_we_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;

    // Search last+1, last+2, ... with an explicit wrap so non-power-of-2 N works.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last} + (GW+1)'(k);
            if (cand >= (GW+1)'(N)) begin
                cand = cand - (GW+1)'(N);
            end
            if (!sel_found && bus.req_valid[cand[GW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = BUSY;
            BUSY:    if (bus.mem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset abandons any in-flight transaction: cs drops and no ack is ever issued for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last        <= GW'(N - 1);
            grant_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        mem_cs_q    <= 1'b1;
                        mem_we_q    <= bus.req_we[sel_idx];
                        mem_addr_q  <= bus.req_addr[int'(sel_idx)*AW +: AW];
                        mem_wdata_q <= bus.req_wdata[int'(sel_idx)*DW +: DW];
                        grant_q     <= sel_idx;
                        last        <= sel_idx;
                        busy_q      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        mem_cs_q <= 1'b0;
                        if (!mem_we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        ack_q <= ACK_ONE << grant_q;
                    end
                end
                DONE: begin
                    ack_q  <= '0;
                    busy_q <= 1'b0;
                end
                default: begin
                    ack_q <= '0;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Structural invariants of the registered outputs.
    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack_q));
    a_ack_no_cs:  assert property (@(posedge clk) disable iff (rst) (ack_q != '0) |-> !mem_cs_q);
    a_cs_busy:    assert property (@(posedge clk) disable iff (rst) mem_cs_q |-> busy_q);

endmodule

// File: tb/tb_mem_req_mux.sv
// Directed bench for mem_req_mux: N=2 instance for the main transaction scenarios,
// N=3 instance for round-robin wrap with a non-power-of-2 channel count.
module tb_mem_req_mux;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        int            ch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_req_mux_if #(.N(2), .AW(AW), .DW(DW)) bus2 ();
    mem_req_mux_if #(.N(3), .AW(AW), .DW(DW)) bus3 ();

    mem_req_mux #(.N(2), .AW(AW), .DW(DW)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mem_req_mux #(.N(3), .AW(AW), .DW(DW)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    txn_t          sb2[$];
    int            exp3[$];
    logic [DW-1:0] rdata_model;
    int            checks = 0;
    int            errors = 0;
    int            w;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input int ch, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rd);
        txn_t t;
        t.ch    = ch;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = rd;
        sb2.push_back(t);
    endtask

    // Raise a channel's request with its fields and queue the transaction it should produce.
    task automatic applyStimulus(input int ch, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] rd);
        bus2.req_valid[ch]           = 1'b1;
        bus2.req_we[ch]              = we;
        bus2.req_addr[ch*AW +: AW]   = addr;
        bus2.req_wdata[ch*DW +: DW]  = wdata;
        pushExpect(ch, we, addr, wdata, rd);
    endtask

    // Memory-side responder for dut2: waits for cs, checks the presented request against
    // the scoreboard, acks after 'latency' BUSY cycles and checks the returned ack/rdata.
    task automatic serveMem(input int latency, input logic keepAck, input logic keepReq,
                            input int injectCh, output int waited);
        txn_t          t;
        logic [DW-1:0] exp_rd;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus2.mem_cs !== 1'b1 && waited < 20);
        if (bus2.mem_cs !== 1'b1) begin
            checkOutput("mem_cs_timeout", bus2.mem_cs, 1);
            return;
        end
        if (sb2.size() == 0) begin
            checkOutput("scoreboard_empty", sb2.size(), 1);
            return;
        end
        t = sb2.pop_front();
        checkOutput("grant_id", bus2.grant_id, t.ch);
        checkOutput("mem_we", bus2.mem_we, t.we);
        checkOutput("mem_addr", bus2.mem_addr, t.addr);
        checkOutput("mem_wdata", bus2.mem_wdata, t.wdata);
        checkOutput("busy_in_busy", bus2.busy, 1);
        for (int i = 1; i < latency; i++) begin
            if (i == 2 && injectCh >= 0) begin
                applyStimulus(injectCh, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D);
            end
            @(negedge clk);
            checkOutput("mem_cs_hold", bus2.mem_cs, 1);
            checkOutput("mem_addr_hold", bus2.mem_addr, t.addr);
            checkOutput("mem_wdata_hold", bus2.mem_wdata, t.wdata);
            checkOutput("grant_hold", bus2.grant_id, t.ch);
            checkOutput("ack_early", bus2.ack, 0);
        end
        bus2.mem_ack   = 1'b1;
        bus2.mem_rdata = t.rdata;
        @(negedge clk);
        if (!keepAck) bus2.mem_ack = 1'b0;
        exp_rd      = t.we ? rdata_model : t.rdata;
        rdata_model = exp_rd;
        checkOutput("ack_pulse", bus2.ack, 64'(1) << t.ch);
        checkOutput("rdata", bus2.rdata, exp_rd);
        checkOutput("mem_cs_done", bus2.mem_cs, 0);
        if (!keepReq) bus2.req_valid[t.ch] = 1'b0;
        @(negedge clk);
        checkOutput("ack_pulse_end", bus2.ack, 0);
        checkOutput("busy_after_done", bus2.busy, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus2.req_valid = '0;
        bus2.mem_ack   = 1'b0;
        bus3.req_valid = '0;
        bus3.mem_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdata_model = '0;
        sb2.delete();
    endtask

    initial begin
        rst            = 1'b1;
        rdata_model    = '0;
        bus2.req_valid = '0;
        bus2.req_we    = '0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        bus2.mem_ack   = 1'b0;
        bus2.mem_rdata = '0;
        bus3.req_valid = '0;
        bus3.req_we    = '0;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;
        bus3.mem_ack   = 1'b0;
        bus3.mem_rdata = '0;

        // Reset values.
        @(negedge clk);
        checkOutput("rst_ack", bus2.ack, 0);
        checkOutput("rst_rdata", bus2.rdata, 0);
        checkOutput("rst_grant_id", bus2.grant_id, 0);
        checkOutput("rst_busy", bus2.busy, 0);
        checkOutput("rst_mem_cs", bus2.mem_cs, 0);
        checkOutput("rst_mem_we", bus2.mem_we, 0);
        checkOutput("rst_mem_addr", bus2.mem_addr, 0);
        checkOutput("rst_mem_wdata", bus2.mem_wdata, 0);
        checkOutput("rst_n3_mem_cs", bus3.mem_cs, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_req_cs", bus2.mem_cs, 0);
        checkOutput("idle_no_req_busy", bus2.busy, 0);

        // Single read from channel 0.
        $display("[TB] single read ch0");
        applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
        serveMem(2, 1'b0, 1'b0, -1, w);
        checkOutput("read_grant_latency", w, 1);

        // Both channels requesting continuously with mem_ack held high.
        $display("[TB] continuous requests, N=2");
        doReset();
        applyStimulus(0, 1'b0, 32'h0000_0500, 32'h0, 32'h1111_1111);
        applyStimulus(1, 1'b1, 32'h0000_0600, 32'hA5A5_A5A5, 32'h2222_2222);
        pushExpect(0, 1'b0, 32'h0000_0500, 32'h0, 32'h3333_3333);
        pushExpect(1, 1'b1, 32'h0000_0600, 32'hA5A5_A5A5, 32'h4444_4444);
        for (int n = 0; n < 4; n++) begin
            serveMem(1, 1'b1, 1'b1, -1, w);
            checkOutput("rr_grant_spacing", w, 1);
        end
        bus2.req_valid = '0;
        bus2.mem_ack   = 1'b0;
        @(negedge clk);

        // Long write on channel 1; channel 0 arrives mid-transaction and must wait.
        $display("[TB] delayed write ch1 with ch0 arriving mid-way");
        applyStimulus(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'hBAD0_BAD0);
        serveMem(5, 1'b0, 1'b0, 0, w);
        checkOutput("write_grant_latency", w, 1);
        serveMem(1, 1'b0, 1'b0, -1, w);
        checkOutput("late_ch0_grant_latency", w, 1);

        // Reset asserted in the middle of a BUSY transaction.
        $display("[TB] reset during BUSY");
        applyStimulus(1, 1'b0, 32'h0000_0700, 32'h0, 32'h5555_5555);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus2.mem_cs !== 1'b1 && w < 20);
        checkOutput("abort_mem_cs_up", bus2.mem_cs, 1);
        checkOutput("abort_grant_id", bus2.grant_id, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_cs_async", bus2.mem_cs, 0);
        checkOutput("abort_busy_async", bus2.busy, 0);
        sb2.delete();
        rdata_model = '0;
        applyStimulus(0, 1'b0, 32'h0000_0780, 32'h0, 32'h6666_6666);
        applyStimulus(1, 1'b0, 32'h0000_0700, 32'h0, 32'h5555_5555);
        @(negedge clk);
        checkOutput("abort_no_ack", bus2.ack, 0);
        checkOutput("abort_rdata_cleared", bus2.rdata, 0);
        rst = 1'b0;
        serveMem(1, 1'b0, 1'b0, -1, w);
        checkOutput("post_reset_grant_latency", w, 1);
        serveMem(1, 1'b0, 1'b0, -1, w);

        // Spurious mem_ack in IDLE, then held through DONE.
        $display("[TB] spurious mem_ack");
        bus2.mem_ack = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("idle_spurious_ack", bus2.ack, 0);
            checkOutput("idle_spurious_cs", bus2.mem_cs, 0);
            checkOutput("idle_spurious_busy", bus2.busy, 0);
        end
        bus2.mem_ack = 1'b0;
        applyStimulus(0, 1'b0, 32'h0000_0900, 32'h0, 32'h7777_7777);
        serveMem(1, 1'b1, 1'b0, -1, w);
        @(negedge clk);
        checkOutput("done_spurious_ack", bus2.ack, 0);
        checkOutput("done_spurious_cs", bus2.mem_cs, 0);
        bus2.mem_ack = 1'b0;

        // N=3 wrap: requests 101 continuously, grants must alternate 0,2,0,2.
        $display("[TB] N=3 round-robin wrap");
        doReset();
        bus3.req_addr[0*AW +: AW] = 32'h0000_0300;
        bus3.req_addr[1*AW +: AW] = 32'h0000_0310;
        bus3.req_addr[2*AW +: AW] = 32'h0000_0320;
        exp3 = '{0, 2, 0, 2};
        bus3.req_valid = 3'b101;
        bus3.mem_ack   = 1'b1;
        for (int n = 0; n < 40 && exp3.size() > 0; n++) begin
            @(negedge clk);
            if (bus3.ack != '0) begin
                int e;
                e = exp3.pop_front();
                checkOutput("n3_ack", bus3.ack, 64'(1) << e);
                checkOutput("n3_grant_id", bus3.grant_id, e);
                checkOutput("n3_mem_addr", bus3.mem_addr, 64'(32'h0000_0300 + 32'(e) * 32'h10));
            end
        end
        checkOutput("n3_all_grants_seen", exp3.size(), 0);
        bus3.req_valid = '0;
        bus3.mem_ack   = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
